// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive FIFO behind a UART receiver with sticky overflow
//
// Purpose: captures each byte presented with the receiver's one-cycle done strobe
//          into a circular buffer and presents the head entry combinationally to
//          a consumer. A write arriving while the buffer is full, with no read in
//          the same cycle, is dropped and sets a sticky overflow flag.
//
// Optional feature: define UART_RX_FIFO_DROP_CNT_EN to add an 8-bit saturating
//                   drop_cnt output counting dropped writes.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   wr_tick      in   one-cycle write strobe (receiver rx_done_tick)
//   wr_data      in   byte to store, sampled with wr_tick
//   rd           in   pop request, honoured when not empty
//   rd_data      out  head entry, valid while empty=0
//   empty        out  count==0
//   full         out  count==2**ADDR_W
//   almost_full  out  count>=AF_LEVEL
//   count        out  number of stored entries
//   overflow     out  sticky dropped-write flag
//   clr_ovf      in   one-cycle pulse clearing overflow
//   drop_cnt     out  saturating dropped-write counter (UART_RX_FIFO_DROP_CNT_EN only)

module uart_rx_fifo #(
    parameter int DBIT     = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_tick,
    input  logic [DBIT-1:0]   wr_data,
    input  logic              rd,
    output logic [DBIT-1:0]   rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_LEVEL);

    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic wr_en;
    logic rd_en;
    logic drop;

    // Flags decode straight from the registered count so nothing on the
    // output side has a combinational path from wr_tick.
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign almost_full = (count_q >= AF_CNT);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign rd_data     = mem_q[rd_ptr_q];

    // A read while full frees the slot this same edge, so the write is
    // taken instead of dropped.
    assign rd_en = rd && !empty;
    assign wr_en = wr_tick && (!full || rd);
    assign drop  = wr_tick && full && !rd;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as clr_ovf must leave the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; stale entries are unreachable
    // because the pointers and count are.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model

module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_tick = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    uart_rx_fifo #(
        .DBIT     (8),
        .ADDR_W   (4),
        .AF_LEVEL (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_tick     (wr_tick),
        .wr_data     (wr_data),
        .rd          (rd),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
`ifdef UART_RX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a byte queue plus a sticky flag and a drop tally.
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_drop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            bit was_empty, was_full, do_rd, do_wr, dropped;
            was_empty = (mq.size() == 0);
            was_full  = (mq.size() == DEPTH);
            do_rd     = rd && !was_empty;
            do_wr     = wr_tick && (!was_full || rd);
            dropped   = wr_tick && was_full && !rd;
            if (do_rd) void'(mq.pop_front());
            if (do_wr) mq.push_back(wr_data);
            if (dropped) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            if (clr_ovf) m_drop = dropped ? 1 : 0;
            else if (dropped && m_drop < 255) m_drop++;
        end
    end

    // Every-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("empty",       32'(empty),       32'(mq.size() == 0));
            chk("full",        32'(full),        32'(mq.size() == DEPTH));
            chk("almost_full", 32'(almost_full), 32'(mq.size() >= 12));
            chk("count",       32'(count),       32'(mq.size()));
            chk("overflow",    32'(overflow),    32'(m_ovf));
            if (mq.size() != 0) chk("rd_data", 32'(rd_data), 32'(mq[0]));
`ifdef UART_RX_FIFO_DROP_CNT_EN
            chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
`endif
        end
    end

    task automatic step(input logic wt, input logic [7:0] wd, input logic r, input logic c);
        wr_tick = wt;
        wr_data = wd;
        rd      = r;
        clr_ovf = c;
        @(posedge clk);
        #1;
        wr_tick = 1'b0;
        rd      = 1'b0;
        clr_ovf = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_af",    32'(almost_full), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 8'h00, 0, 0);

        // Single byte in and out
        step(1, 8'hA5, 0, 0);
        chk("a5_empty", 32'(empty), 32'd0);
        chk("a5_count", 32'(count), 32'd1);
        chk("a5_data",  32'(rd_data), 32'hA5);
        chk("a5_model", 32'(mq.size()), 32'd1);
        step(0, 8'h00, 1, 0);
        chk("a5_empty_after", 32'(empty), 32'd1);
        chk("a5_count_after", 32'(count), 32'd0);

        // Read on empty is ignored
        step(0, 8'h00, 1, 0);
        chk("rd_empty_count", 32'(count), 32'd0);

        // Fill to full, watching almost_full threshold
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0);
            chk("fill_af",   32'(almost_full), 32'(i + 1 >= 12));
            chk("fill_full", 32'(full),        32'(i + 1 == 16));
        end
        chk("fill_count", 32'(count), 32'd16);

        // Dropped write while full
        step(1, 8'h55, 0, 0);
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_ovf",   32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_cnt1",  32'(drop_cnt), 32'd1);
`endif
        step(0, 8'h00, 0, 1);
        chk("clr_ovf0",   32'(overflow), 32'd0);

        // Write plus read while full: both accepted
        step(1, 8'h77, 1, 0);
        chk("wr_rd_full_count", 32'(count), 32'd16);
        chk("wr_rd_full_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(rd_data), (i < 15) ? 32'(i + 1) : 32'h77);
            step(0, 8'h00, 1, 0);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Write and read while empty: write wins
        step(1, 8'h3C, 1, 0);
        chk("wr_rd_empty_count", 32'(count), 32'd1);
        chk("wr_rd_empty_data",  32'(rd_data), 32'h3C);
        step(0, 8'h00, 1, 0);

        // Pointer wrap with interleaved write/read
        for (int i = 0; i < 40; i++) begin
            step(1, 8'(8'h80 + i), 0, 0);
            chk("wrap_data",  32'(rd_data), 32'(8'(8'h80 + i)));
            chk("wrap_count", 32'(count), 32'd1);
            step(0, 8'h00, 1, 0);
        end

        // clr_ovf colliding with a drop: set wins
        for (int i = 0; i < 16; i++) step(1, 8'(8'hC0 + i), 0, 0);
        step(1, 8'hEE, 0, 0);
        step(1, 8'hEF, 0, 1);
        chk("clr_vs_drop_ovf", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("clr_vs_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        step(0, 8'h00, 0, 1);
        chk("clr_alone_ovf", 32'(overflow), 32'd0);
        chk("clr_keeps_data", 32'(rd_data), 32'hC0);

        // Asynchronous reset mid-operation with count=5
        for (int i = 0; i < 11; i++) step(0, 8'h00, 1, 0);
        chk("pre_rst_count", 32'(count), 32'd5);
        reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        step(1, 8'h99, 0, 0);
        reset = 1'b1;
        step(0, 8'h00, 0, 0);
        chk("lost_tick_count", 32'(count), 32'd0);

        // Randomized traffic in segments with different fill pressure
        for (int seg = 0; seg < 12; seg++) begin
            int pw, pr;
            pw = $urandom_range(20, 95);
            pr = $urandom_range(20, 95);
            for (int c = 0; c < 250; c++) begin
                step(($urandom % 100) < pw, 8'($urandom), ($urandom % 100) < pr,
                     ($urandom % 100) < 3);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART receiver.
- Captures each byte presented with the receiver's one-cycle done strobe and holds it in a circular FIFO.
- Presents the bytes show-ahead to a consumer, such as a command parser or bus register interface.
- Flags overflow when bytes arrive faster than they are drained.

Parameters:
- DBIT, 8, data width in bits; must match the receiver's data width.
- ADDR_W, 4, address width; FIFO depth = 2**ADDR_W entries.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets the block immediately.
- wr_tick  in  1  write strobe, one clk wide; connects to the receiver's rx_done_tick.
- wr_data  in  DBIT  byte to store; connects to the receiver's dout; sampled only when wr_tick=1.
- rd  in  1  pop request; one entry removed per clk in which rd=1 and empty=0.
- rd_data  out  DBIT  head entry (show-ahead); valid whenever empty=0.
- empty  out  1  1 when count==0.
- full  out  1  1 when count==2**ADDR_W.
- almost_full  out  1  1 when count>=AF_LEVEL.
- count  out  ADDR_W+1  number of stored entries, 0..2**ADDR_W.
- overflow  out  1  sticky flag: a write was dropped.
- clr_ovf  in  1  one-cycle pulse that clears overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs: empty=1, full=0, almost_full=0.
  - rd_data = don't-care. Memory contents are not reset.
- Storage: register array mem[0..2**ADDR_W-1] of DBIT bits.
  - Pointers are ADDR_W bits and wrap naturally from 2**ADDR_W-1 to 0.
- Flags:
  - empty, full, almost_full are decoded combinationally from the registered count; no extra latency.
  - rd_data = mem[rd_ptr], combinational read.
- Write: on a clk edge with wr_tick=1 and (full=0, or full=1 with rd=1):
  - mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1.
  - Write-to-read latency is 1 clk: empty deasserts and rd_data shows the byte in the cycle after the wr_tick edge.
- Read: on a clk edge with rd=1 and empty=0: rd_ptr <= rd_ptr+1. rd=1 while empty=1 is ignored; no pointer change, no error flag.
- Count update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous events:
  - Write and read while empty=1: the write is accepted and the read is ignored; count becomes 1.
  - Write and read while full=1: both are accepted; count stays 2**ADDR_W; overflow unchanged.
  - Write while full=1 with rd=0: the byte is dropped, pointers and memory are unchanged, overflow <= 1.
  - clr_ovf=1 in the same cycle as a drop: the set wins and overflow stays 1.
- clr_ovf otherwise clears overflow on the next edge. Stored data is unaffected.
- No internal state machine beyond pointers, count and flag. All outputs are registered or decoded from registers; no combinational path from wr_tick to any output.
- Reset mid-operation: all buffered bytes are discarded. A wr_tick arriving while reset=0 is lost.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt, 8 bits.
  - drop_cnt increments on every dropped write and saturates at 255.
  - Cleared to 0 by reset or clr_ovf; an increment in the same cycle as clr_ovf yields 1.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then write 0xA5 with one wr_tick -> next cycle empty=0, count=1, rd_data=0xA5; pulse rd -> empty=1, count=0.
- Write 16 bytes 0x00..0x0F with default params -> almost_full=1 from count=12, full=1 at count=16; read all 16 -> rd_data sequence 0x00..0x0F in order, empty=1 at end.
- FIFO full, write 0x55 with rd=0 -> count stays 16, overflow=1, data read out still 0x00..0x0F; with DROP_CNT_EN, drop_cnt=1.
- FIFO full, wr_tick with 0x77 and rd=1 in the same cycle -> count=16, overflow=0, 0x77 is the last byte read out.
- Pointer wrap: 40 interleaved single writes/reads of an incrementing pattern -> every byte read matches the written value, count never exceeds 1.
- With overflow=1, pulse clr_ovf together with a dropped write -> overflow stays 1; pulse clr_ovf alone -> overflow=0. Assert reset=0 with count=5 -> empty=1 and count=0 immediately, before the next clk edge.
